// File: rtl/game_engine.sv
// game_engine: per-frame game state for the flappy-bird display path.
// Keeps bird height/velocity, three scrolling pipes with pseudo-random gap
// heights, collision detection and the score. State advances only on
// frame_tick (once per frame, in vertical blanking).
//
// Ports:
//   clk_div      pixel clock
//   rst_n        asynchronous active-low reset
//   frame_tick   one-cycle pulse per frame
//   flap         button level (asynchronous; synchronised here)
//   bird_x/y     bird top-left corner
//   pipeN_x      pipe left edge, N = 1..3
//   pipeNy_up    bottom of upper pipe; the gap is [y_up, y_up+GAP)
//   score        pipes passed, saturating at 255
//   playing      high in PLAY
//   game_over    high in DEAD
//   dbg_state    raw FSM state (0 IDLE, 1 PLAY, 2 DEAD)
//
// Handshake: there is no valid/ready pair; frame_tick acts as a one-cycle
// valid with the engine always ready, and a flap edge is held pending until
// the next frame_tick consumes it.
module game_engine #(
  parameter int SCREEN_H     = 480,
  parameter int BIRD_X       = 100,
  parameter int BIRD_SIZE    = 20,
  parameter int PIPE_W       = 40,
  parameter int GAP          = 80,
  parameter int PIPE_SPACING = 240,
  parameter int PIPE_SPEED   = 2,
  parameter int GRAVITY      = 1,
  parameter int FLAP_VEL     = 8,
  parameter int MAX_FALL     = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk_div,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       flap,
  output logic [9:0] bird_x,
  output logic [9:0] bird_y,
  output logic [9:0] pipe1_x,
  output logic [9:0] pipe2_x,
  output logic [9:0] pipe3_x,
  output logic [9:0] pipe1y_up,
  output logic [9:0] pipe2y_up,
  output logic [9:0] pipe3y_up,
  output logic [7:0] score,
  output logic       playing,
  output logic       game_over,
  output logic [1:0] dbg_state
);

  localparam logic [9:0] X_BIRD = 10'(BIRD_X);
  localparam logic [9:0] SZ     = 10'(BIRD_SIZE);
  localparam logic [9:0] PW     = 10'(PIPE_W);
  localparam logic [9:0] GAPW   = 10'(GAP);
  localparam logic [9:0] SPD    = 10'(PIPE_SPEED);
  localparam logic [9:0] Y_MAX  = 10'(SCREEN_H - BIRD_SIZE);
  localparam logic [9:0] WRAP   = 10'(3 * PIPE_SPACING - PIPE_SPEED);
  localparam logic signed [5:0] V_FLAP = 6'(-FLAP_VEL);
  localparam logic signed [5:0] V_GRAV = 6'(GRAVITY);
  localparam logic signed [5:0] V_MAX  = 6'(MAX_FALL);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} state_t;
  state_t state, state_nx;

  logic [9:0]        y, y_nx, u_y;
  logic signed [5:0] vel, vel_nx, u_vel, v_inc, v_t;
  logic signed [10:0] y_sum;
  logic [9:0]        px[3], py[3], px_nx[3], py_nx[3], u_px[3], u_py[3];
  logic [7:0]        scr, scr_nx, u_scr;
  logic [8:0]        scr_sum;
  logic [1:0]        passed;
  logic [9:0]        gap_rand;
  logic [7:0]        lfsr;
  logic              s1, s2, s3, pend, edge_det, flap_now, collide;

  // Flap: two-flop synchroniser, then rising-edge detect. An edge arriving
  // together with frame_tick is consumed by that tick.
  assign edge_det = s2 & ~s3;
  assign flap_now = pend | edge_det;

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      pend <= 1'b0;
      lfsr <= LFSR_SEED;
    end else begin
      s1 <= flap;
      s2 <= s1;
      s3 <= s2;
      if (frame_tick) pend <= 1'b0;
      else if (edge_det) pend <= 1'b1;
      // x^8+x^6+x^5+x^4+1, free running in every state
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign gap_rand = 10'd40 + {7'd0, lfsr[2:0]} * 10'd40;

  // Candidate PLAY update and collision check on current registered values.
  always_comb begin
    v_inc = vel + V_GRAV;
    if (flap_now) v_t = V_FLAP;
    else if (v_inc > V_MAX) v_t = V_MAX;
    else v_t = v_inc;
    y_sum = $signed({1'b0, y}) + $signed({{5{v_t[5]}}, v_t});
    u_vel = v_t;
    u_y   = y_sum[9:0];
    if (y_sum < 11'sd0) begin
      u_y   = '0;
      u_vel = '0;
    end else if (y_sum > $signed({1'b0, Y_MAX})) begin
      u_y = Y_MAX;
    end
    passed  = '0;
    collide = (y >= Y_MAX);
    for (int i = 0; i < 3; i++) begin
      if (px[i] < SPD) begin
        u_px[i] = px[i] + WRAP;
        u_py[i] = gap_rand;
      end else begin
        u_px[i] = px[i] - SPD;
        u_py[i] = py[i];
      end
      if ((px[i] + PW >= X_BIRD) && (u_px[i] + PW < X_BIRD)) passed = passed + 2'd1;
      if ((px[i] < X_BIRD + SZ) && (px[i] + PW > X_BIRD) &&
          ((y < py[i]) || (y + SZ > py[i] + GAPW))) collide = 1'b1;
    end
    scr_sum = {1'b0, scr} + {7'd0, passed};
    u_scr   = scr_sum[8] ? 8'hFF : scr_sum[7:0];
  end

  // Next-state / next-value logic.
  always_comb begin
    state_nx = state;
    y_nx     = y;
    vel_nx   = vel;
    scr_nx   = scr;
    for (int i = 0; i < 3; i++) begin
      px_nx[i] = px[i];
      py_nx[i] = py[i];
    end
    if (frame_tick) begin
      case (state)
        IDLE, PLAY: begin
          if (state == PLAY && collide) begin
            state_nx = DEAD;
          end else if (state == PLAY || flap_now) begin
            state_nx = PLAY;
            y_nx     = u_y;
            vel_nx   = u_vel;
            scr_nx   = u_scr;
            for (int i = 0; i < 3; i++) begin
              px_nx[i] = u_px[i];
              py_nx[i] = u_py[i];
            end
          end
        end
        DEAD: begin
          if (flap_now) begin
            state_nx = IDLE;
            y_nx     = 10'd230;
            vel_nx   = '0;
            scr_nx   = '0;
            px_nx[0] = 10'd400;
            px_nx[1] = 10'd640;
            px_nx[2] = 10'd880;
            py_nx[0] = 10'd200;
            py_nx[1] = 10'd160;
            py_nx[2] = 10'd240;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      y     <= 10'd230;
      vel   <= '0;
      scr   <= '0;
      px[0] <= 10'd400;
      px[1] <= 10'd640;
      px[2] <= 10'd880;
      py[0] <= 10'd200;
      py[1] <= 10'd160;
      py[2] <= 10'd240;
    end else begin
      y   <= y_nx;
      vel <= vel_nx;
      scr <= scr_nx;
      for (int i = 0; i < 3; i++) begin
        px[i] <= px_nx[i];
        py[i] <= py_nx[i];
      end
    end
  end

  assign bird_x    = X_BIRD;
  assign bird_y    = y;
  assign pipe1_x   = px[0];
  assign pipe2_x   = px[1];
  assign pipe3_x   = px[2];
  assign pipe1y_up = py[0];
  assign pipe2y_up = py[1];
  assign pipe3y_up = py[2];
  assign score     = scr;
  assign playing   = (state == PLAY);
  assign game_over = (state == DEAD);
  assign dbg_state = state;

endmodule
